qeciphy_link_test_ctrl: RTL
===========================

Name: qeciphy_link_test_ctrl

Overview:
- Sequences a QECI-PHY link self-test in the board example designs.
- Waits for link-up, then streams a counter pattern into the PHY TX AXI-Stream channel for a programmed word count.
- Checks the looped-back or far-end RX stream against the same pattern, and reports pass/fail with error counts.
- Sits between the PHY (STATUS/ECODE, TX/RX AXI-Stream) and the debug VIO/ILA, replacing free-running ad-hoc generator/checker logic.

Parameters:
- DATA_W, 64, TX/RX AXI-Stream data width.
- LINK_UP_CODE, 4'b0100, STATUS value meaning link up.
- TIMEOUT_CYCLES, 2**24, max ACLK cycles in WAIT_LINK, and max cycles in DRAIN without an RX beat.
- CNT_W, 32, width of num_words, tx_count and rx_count.

Ports:
- ACLK, in, 1: clock for all logic.
- rst_n, in, 1: reset.
- start, in, 1: level; sampled in IDLE/DONE.
- stop, in, 1: abort request.
- num_words, in, CNT_W: words to send/check; latched on start.
- status, in, 4: PHY STATUS.
- ecode, in, 4: PHY ECODE.
- tx_tdata, out, DATA_W: TX data to PHY.
- tx_tvalid, out, 1: TX valid.
- tx_tready, in, 1: TX ready from PHY.
- rx_tdata, in, DATA_W: RX data from PHY.
- rx_tvalid, in, 1: RX valid.
- rx_tready, out, 1: RX ready.
- busy, out, 1: state in WAIT_LINK/RUN/DRAIN.
- done, out, 1: state == DONE.
- pass, out, 1: valid when done.
- fail_code, out, 2: 0 none, 1 timeout, 2 link lost, 3 aborted.
- err_count, out, 16: saturating mismatch count.
- tx_count, out, CNT_W: TX handshakes this run.
- rx_count, out, CNT_W: RX beats checked this run.
- state_o, out, 3: FSM state encoding.

Behaviour:
- Interface: reset is rst_n, asynchronous, active-low; clock is ACLK. All flops are reset asynchronously by rst_n.
- Reset values:
  - state IDLE; tx_tvalid 0; tx_tdata 0; busy/done/pass 0.
  - fail_code 0; err_count, tx_count, rx_count 0; num_words latch 0.
  - rx_tready is constant 1: the QECI RX path has no backpressure.
- FSM encoding: IDLE=0, WAIT_LINK=1, RUN=2, DRAIN=3, DONE=4.
- IDLE/DONE + start=1 + stop=0 -> WAIT_LINK next cycle:
  - latch num_words;
  - clear counters, err_count, fail_code, pass;
  - clear timeout counter.
- start and stop both high in IDLE/DONE: stop wins; state unchanged.
- WAIT_LINK:
  - status==LINK_UP_CODE and ecode==0 -> RUN, or -> DONE with pass=1 if the latched num_words==0.
  - Timeout counter reaching TIMEOUT_CYCLES-1 -> DONE, fail_code=1.
- RUN:
  - tx_tvalid=1; tx_tdata = zero-extended tx_count.
  - On tx_tvalid&&tx_tready, tx_count increments. tx_tdata updates in the same registered cycle, so back-to-back beats run at 1 word/cycle.
  - After the handshake that makes tx_count==num_words, tx_tvalid=0 next cycle -> DRAIN.
- RX check, active in RUN and DRAIN only:
  - Each rx_tvalid beat compares rx_tdata against zero-extended rx_count; on mismatch err_count += 1, saturating at 16'hFFFF.
  - rx_count increments every beat regardless of match.
  - RX beats in IDLE, WAIT_LINK or DONE are discarded and not counted.
  - Beats beyond num_words are discarded.
- DRAIN:
  - rx_count==num_words -> DONE.
  - Timeout counter, reset on every RX beat, reaching TIMEOUT_CYCLES-1 -> DONE, fail_code=1.
- Link loss: in RUN or DRAIN, status!=LINK_UP_CODE or ecode!=0 -> DONE, fail_code=2.
- Abort: stop=1 in WAIT_LINK/RUN/DRAIN -> DONE, fail_code=3.
  - Priority: stop > link loss > timeout > normal completion.
- tx_tvalid may drop without a handshake only on abort, link loss or leaving RUN; otherwise it is held until tx_tready.
- DONE: pass = (fail_code==0 && err_count==0). done/pass/fail_code/counters hold until the next start.
- Reset asserted mid-run: immediate return to reset values; no completion reported.
- CNT_W wrap is impossible: counting stops at num_words.

Optional Feature:
- Macro: QECIPHY_LINK_TEST_ERR_CAPTURE_EN.
- Defined:
  - Adds outputs first_err_valid (1), first_err_index (CNT_W), first_err_exp (DATA_W), first_err_got (DATA_W).
  - These capture the first mismatch of a run; they are cleared on start and held afterwards.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Loopback rx=tx delayed 5 cycles, status=4'b0100, num_words=1000, tready=1 -> DONE; tx_count=rx_count=1000, err_count=0, pass=1, fail_code=0.
- Same, with tready toggling 1/0 and rx_tdata word 37 corrupted -> tx_tdata stable while stalled; err_count=1, pass=0, fail_code=0; with macro, first_err_index=37, first_err_exp=37.
- status held 4'b0001, TIMEOUT_CYCLES=64 -> DONE after 64 cycles in WAIT_LINK with fail_code=1; tx_tvalid never 1.
- Mid-RUN (tx_count=200) status drops -> DONE next cycle, fail_code=2, tx_tvalid=0; then start again -> counters cleared, full pass.
- stop during DRAIN, and start+stop together in IDLE -> DONE with fail_code=3 for the first case; the second stays IDLE.
- num_words=0 with link up -> DONE with pass=1 and no TX beats; async rst_n pulse mid-RUN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/qeciphy_link_test_ctrl.sv
`default_nettype none
// ============================================================================
// qeciphy_link_test_ctrl: QECI-PHY link self-test sequencer (TX counter
// pattern, RX pattern check). Optional QECIPHY_LINK_TEST_ERR_CAPTURE_EN adds
// first-mismatch capture ports.                                      Rev 1.0
// ============================================================================
module qeciphy_link_test_ctrl #(
  parameter int         DATA_W         = 64,
  parameter logic [3:0] LINK_UP_CODE   = 4'b0100,
  parameter int         TIMEOUT_CYCLES = 2**24,
  parameter int         CNT_W          = 32
) (
  input  logic              ACLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [3:0]        status,
  input  logic [3:0]        ecode,
  output logic [DATA_W-1:0] tx_tdata,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  input  logic [DATA_W-1:0] rx_tdata,
  input  logic              rx_tvalid,
  output logic              rx_tready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [15:0]       err_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic [2:0]        state_o
`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
  ,
  output logic              first_err_valid,
  output logic [CNT_W-1:0]  first_err_index,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
`endif
);

  localparam int              TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    RUN       = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   nwords_q, nwords_d;
  logic [CNT_W-1:0]   tx_count_q, tx_count_d;
  logic [CNT_W-1:0]   rx_count_q, rx_count_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [1:0]         fail_code_q, fail_code_d;
  logic               tx_tvalid_q, tx_tvalid_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic               link_ok;
  logic               tx_hs;
  logic               rx_take;
  logic               rx_bad;
  logic [CNT_W-1:0]   tx_inc;
  logic [DATA_W-1:0]  rx_exp;

`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
  logic               fe_valid_q, fe_valid_d;
  logic [CNT_W-1:0]   fe_index_q, fe_index_d;
  logic [DATA_W-1:0]  fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0]  fe_got_q, fe_got_d;
`endif

  assign link_ok = (status == LINK_UP_CODE) && (ecode == 4'd0);
  assign tx_hs   = tx_tvalid_q && tx_tready;
  assign tx_inc  = tx_count_q + CNT_W'(1);
  assign rx_exp  = DATA_W'(rx_count_q);
  // Beats past the programmed count are dropped so rx_count never wraps.
  assign rx_take = ((state_q == RUN) || (state_q == DRAIN)) && rx_tvalid &&
                   (rx_count_q != nwords_q);
  assign rx_bad  = rx_take && (rx_tdata != rx_exp);

  always_comb begin
    state_d     = state_q;
    nwords_d    = nwords_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    fail_code_d = fail_code_q;
    tx_tvalid_d = tx_tvalid_q;
    tmo_d       = tmo_q;
`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
    fe_valid_d  = fe_valid_q;
    fe_index_d  = fe_index_q;
    fe_exp_d    = fe_exp_q;
    fe_got_d    = fe_got_q;
    if (rx_bad && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_index_d = rx_count_q;
      fe_exp_d   = rx_exp;
      fe_got_d   = rx_tdata;
    end
`endif

    if (tx_hs) tx_count_d = tx_inc;
    if (rx_take) begin
      rx_count_d = rx_count_q + CNT_W'(1);
      if (rx_bad && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_d     = WAIT_LINK;
          nwords_d    = num_words;
          tx_count_d  = '0;
          rx_count_d  = '0;
          err_count_d = '0;
          fail_code_d = 2'd0;
          tmo_d       = '0;
`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
          fe_valid_d  = 1'b0;
          fe_index_d  = '0;
          fe_exp_d    = '0;
          fe_got_d    = '0;
`endif
        end
      end
      WAIT_LINK: begin
        if (stop) begin
          state_d     = DONE;
          fail_code_d = 2'd3;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = DONE;
          fail_code_d = 2'd1;
        end else if (link_ok) begin
          if (nwords_q == '0) begin
            state_d = DONE;
          end else begin
            state_d     = RUN;
            tx_tvalid_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RUN: begin
        if (stop || !link_ok) begin
          state_d     = DONE;
          fail_code_d = stop ? 2'd3 : 2'd2;
          tx_tvalid_d = 1'b0;
        end else if (tx_hs && (tx_inc == nwords_q)) begin
          state_d     = DRAIN;
          tx_tvalid_d = 1'b0;
          tmo_d       = '0;
        end
      end
      DRAIN: begin
        if (stop || !link_ok) begin
          state_d     = DONE;
          fail_code_d = stop ? 2'd3 : 2'd2;
        end else if (!rx_tvalid && (tmo_q == TMO_LAST)) begin
          state_d     = DONE;
          fail_code_d = 2'd1;
        end else if (rx_count_q == nwords_q) begin
          state_d = DONE;
        end else begin
          tmo_d = rx_tvalid ? '0 : tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        tx_tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nwords_q    <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      fail_code_q <= 2'd0;
      tx_tvalid_q <= 1'b0;
      tmo_q       <= '0;
`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
      fe_valid_q  <= 1'b0;
      fe_index_q  <= '0;
      fe_exp_q    <= '0;
      fe_got_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nwords_q    <= nwords_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      fail_code_q <= fail_code_d;
      tx_tvalid_q <= tx_tvalid_d;
      tmo_q       <= tmo_d;
`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
      fe_valid_q  <= fe_valid_d;
      fe_index_q  <= fe_index_d;
      fe_exp_q    <= fe_exp_d;
      fe_got_q    <= fe_got_d;
`endif
    end
  end

  // tx_tdata follows the registered count, so it is stable while stalled.
  assign tx_tdata  = DATA_W'(tx_count_q);
  assign tx_tvalid = tx_tvalid_q;
  assign rx_tready = 1'b1;
  assign busy      = (state_q == WAIT_LINK) || (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (fail_code_q == 2'd0) && (err_count_q == 16'd0);
  assign fail_code = fail_code_q;
  assign err_count = err_count_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign state_o   = state_q;

`ifdef QECIPHY_LINK_TEST_ERR_CAPTURE_EN
  assign first_err_valid = fe_valid_q;
  assign first_err_index = fe_index_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;
`endif

endmodule
`default_nettype wire
